// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues one handshaked load/store at a time,
// stalls upstream while busy, and flags misaligned, conflicting or timed-out accesses.
module mem_access_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid_in,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] Addr,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             mem_Stall,
  input  logic             mem_Done,
  input  logic [WIDTH-1:0] mem_DataOut,
  output logic             mem_Rd,
  output logic             mem_Wr,
  output logic [WIDTH-1:0] mem_Addr,
  output logic [WIDTH-1:0] mem_DataIn,
  output logic [WIDTH-1:0] ReadData,
  output logic             Stall_out,
  output logic             Done_out,
  output logic             err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             op_rd_q, op_rd_d;
  logic             op_wr_q, op_wr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic access;
  logic bad_access;
  logic stall_c;

  assign access     = Valid_in & (MemRead | MemWrite);
  assign bad_access = (MemRead & MemWrite) | Addr[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_rd_d = op_rd_q;
    op_wr_d = op_wr_q;
    rdata_d = rdata_q;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (bad_access) begin
            state_d = S_ERR;
          end else begin
            stall_c = 1'b1;
            addr_d  = Addr;
            wdata_d = WriteData;
            op_rd_d = MemRead;
            op_wr_d = MemWrite;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        if (!mem_Stall) begin
          if (mem_Done) begin
            if (op_rd_q) rdata_d = mem_DataOut;
            state_d = S_DONE;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (mem_Done) begin
          if (op_rd_q) rdata_d = mem_DataOut;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: stall_c = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_rd_q <= 1'b0;
      op_wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_rd_q <= op_rd_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign mem_Rd     = (state_q == S_REQ) & op_rd_q;
  assign mem_Wr     = (state_q == S_REQ) & op_wr_q;
  assign mem_Addr   = addr_q;
  assign mem_DataIn = wdata_q;
  assign ReadData   = rdata_q;
  assign Done_out   = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);
  assign Stall_out  = rst & stall_c;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: cycle-by-cycle vector table for the main
// load/store flows, plus hand sequences for timeout, misalignment and async reset.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        Valid_in, MemRead, MemWrite;
  logic [15:0] Addr, WriteData;
  logic        mem_Stall, mem_Done;
  logic [15:0] mem_DataOut;
  logic        mem_Rd, mem_Wr;
  logic [15:0] mem_Addr, mem_DataIn, ReadData;
  logic        Stall_out, Done_out, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(15), .WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .Valid_in(Valid_in), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData),
    .mem_Stall(mem_Stall), .mem_Done(mem_Done), .mem_DataOut(mem_DataOut),
    .mem_Rd(mem_Rd), .mem_Wr(mem_Wr), .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn),
    .ReadData(ReadData), .Stall_out(Stall_out), .Done_out(Done_out), .err(err)
  );

  typedef struct {
    string       name;
    logic        valid, rd, wr;
    logic [15:0] addr, wdata;
    logic        stall, done;
    logic [15:0] dout;
    logic        e_rd, e_wr, e_stall, e_done, e_err;
    logic [15:0] e_addr, e_wdata, e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic valid, logic rd, logic wr,
                              logic [15:0] addr, logic [15:0] wdata,
                              logic stall, logic done, logic [15:0] dout,
                              logic e_rd, logic e_wr, logic e_stall,
                              logic e_done, logic e_err,
                              logic [15:0] e_addr, logic [15:0] e_wdata,
                              logic [15:0] e_rdata);
    vec_t v;
    v.name = name; v.valid = valid; v.rd = rd; v.wr = wr;
    v.addr = addr; v.wdata = wdata; v.stall = stall; v.done = done; v.dout = dout;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_stall = e_stall; v.e_done = e_done;
    v.e_err = e_err; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic valid, logic rd, logic wr, logic [15:0] addr,
                       logic [15:0] wdata, logic stall, logic done, logic [15:0] dout);
    Valid_in = valid; MemRead = rd; MemWrite = wr; Addr = addr; WriteData = wdata;
    mem_Stall = stall; mem_Done = done; mem_DataOut = dout;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);

    //                name      vld rd wr addr     wdata    stl dn dout      eRd eWr eStl eDn eErr eAddr    eWdata   eRdata
    vecs.push_back(mk("ld_idle", 1, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000));
    vecs.push_back(mk("ld_req",  1, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000));
    vecs.push_back(mk("ld_w1",   1, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000));
    vecs.push_back(mk("ld_w2",   1, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000));
    vecs.push_back(mk("ld_w3",   1, 1, 0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000));
    vecs.push_back(mk("ld_done", 1, 1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0010, 16'h0000, 16'hBEEF));
    vecs.push_back(mk("ld_idle2",0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF));
    vecs.push_back(mk("st_idle", 1, 0, 1, 16'h0020, 16'h1234, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'hBEEF));
    vecs.push_back(mk("st_bsy1", 1, 0, 1, 16'h0020, 16'h1234, 1, 0, 16'h0000, 0, 1, 1, 0, 0, 16'h0020, 16'h1234, 16'hBEEF));
    vecs.push_back(mk("st_bsy2", 1, 0, 1, 16'h0020, 16'h1234, 1, 0, 16'h0000, 0, 1, 1, 0, 0, 16'h0020, 16'h1234, 16'hBEEF));
    vecs.push_back(mk("st_acc",  1, 0, 1, 16'h0020, 16'h1234, 0, 1, 16'hDEAD, 0, 1, 1, 0, 0, 16'h0020, 16'h1234, 16'hBEEF));
    vecs.push_back(mk("st_done", 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0020, 16'h1234, 16'hBEEF));
    vecs.push_back(mk("spur1",   0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h5555, 0, 0, 0, 0, 0, 16'h0020, 16'h1234, 16'hBEEF));
    vecs.push_back(mk("b2b_i1",  1, 1, 0, 16'h0002, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0020, 16'h1234, 16'hBEEF));
    vecs.push_back(mk("b2b_r1",  1, 1, 0, 16'h0002, 16'h0000, 0, 1, 16'h1111, 1, 0, 1, 0, 0, 16'h0002, 16'h0000, 16'hBEEF));
    vecs.push_back(mk("b2b_d1",  1, 1, 0, 16'h0004, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0002, 16'h0000, 16'h1111));
    vecs.push_back(mk("b2b_i2",  1, 1, 0, 16'h0004, 16'h0000, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0002, 16'h0000, 16'h1111));
    vecs.push_back(mk("b2b_r2",  1, 1, 0, 16'h0004, 16'h0000, 0, 1, 16'h2222, 1, 0, 1, 0, 0, 16'h0004, 16'h0000, 16'h1111));
    vecs.push_back(mk("b2b_d2",  0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0004, 16'h0000, 16'h2222));
    vecs.push_back(mk("spur2",   0, 0, 0, 16'h0000, 16'h0000, 0, 1, 16'h9999, 0, 0, 0, 0, 0, 16'h0004, 16'h0000, 16'h2222));
    vecs.push_back(mk("idle_end",0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0004, 16'h0000, 16'h2222));

    // Reset state
    #2;
    chk("rst_mem_rd", mem_Rd, 0);
    chk("rst_mem_wr", mem_Wr, 0);
    chk("rst_mem_addr", mem_Addr, 16'h0);
    chk("rst_mem_datain", mem_DataIn, 16'h0);
    chk("rst_readdata", ReadData, 16'h0);
    chk("rst_stall", Stall_out, 0);
    chk("rst_done", Done_out, 0);
    chk("rst_err", err, 0);
    $display("txn reset: outputs checked");
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
            vecs[i].stall, vecs[i].done, vecs[i].dout);
      #2;
      chk({vecs[i].name, ".mem_Rd"}, mem_Rd, vecs[i].e_rd);
      chk({vecs[i].name, ".mem_Wr"}, mem_Wr, vecs[i].e_wr);
      chk({vecs[i].name, ".Stall_out"}, Stall_out, vecs[i].e_stall);
      chk({vecs[i].name, ".Done_out"}, Done_out, vecs[i].e_done);
      chk({vecs[i].name, ".err"}, err, vecs[i].e_err);
      chk({vecs[i].name, ".ReadData"}, ReadData, vecs[i].e_rdata);
      if (vecs[i].e_rd || vecs[i].e_wr) chk({vecs[i].name, ".mem_Addr"}, mem_Addr, vecs[i].e_addr);
      if (vecs[i].e_wr) chk({vecs[i].name, ".mem_DataIn"}, mem_DataIn, vecs[i].e_wdata);
      $display("txn vec %0d %s: checked", i, vecs[i].name);
    end

    // Timeout: no mem_Done ever -> err after exactly 15 WAIT cycles
    do_reset();
    @(negedge clk); drive(1, 1, 0, 16'h0030, 16'h0, 0, 0, 16'h0); #2;
    chk("to_idle.stall", Stall_out, 1);
    @(negedge clk); #2;
    chk("to_req.mem_Rd", mem_Rd, 1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); #2;
      chk($sformatf("to_wait%0d.err", k), err, 0);
      chk($sformatf("to_wait%0d.stall", k), Stall_out, 1);
      chk($sformatf("to_wait%0d.mem_Rd", k), mem_Rd, 0);
    end
    @(negedge clk); #2;
    chk("to_err.err", err, 1);
    chk("to_err.stall", Stall_out, 1);
    chk("to_err.done", Done_out, 0);
    $display("txn timeout no-done: checked");

    // Timeout boundary: mem_Done on the 15th WAIT cycle completes normally
    do_reset();
    @(negedge clk); drive(1, 1, 0, 16'h0032, 16'h0, 0, 0, 16'h0); #2;
    @(negedge clk); #2;
    chk("tb_req.mem_Rd", mem_Rd, 1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 15) begin
        mem_Done = 1'b1; mem_DataOut = 16'hCAFE;
      end
      #2;
      chk($sformatf("tb_wait%0d.err", k), err, 0);
    end
    @(negedge clk); drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0); #2;
    chk("tb_done.Done_out", Done_out, 1);
    chk("tb_done.err", err, 0);
    chk("tb_done.ReadData", ReadData, 16'hCAFE);
    $display("txn timeout boundary: checked");

    // Async reset in WAIT of a read
    @(negedge clk); drive(1, 1, 0, 16'h0050, 16'h0, 0, 0, 16'h0); #2;
    @(negedge clk); #2;
    chk("ar_req.mem_Rd", mem_Rd, 1);
    @(negedge clk); #2;
    chk("ar_wait.stall", Stall_out, 1);
    #1 rst = 1'b0;
    #1;
    chk("ar_wait.mem_Rd", mem_Rd, 0);
    chk("ar_wait.Stall_out", Stall_out, 0);
    chk("ar_wait.ReadData", ReadData, 16'h0);
    chk("ar_wait.err", err, 0);
    // Async reset in REQ: strobe must drop before any clock edge
    @(negedge clk); rst = 1'b1; drive(1, 1, 0, 16'h0060, 16'h0, 1, 0, 16'h0); #2;
    chk("ar_idle.stall", Stall_out, 1);
    @(negedge clk); #2;
    chk("ar_req2.mem_Rd", mem_Rd, 1);
    chk("ar_req2.mem_Addr", mem_Addr, 16'h0060);
    #1 rst = 1'b0;
    #1;
    chk("ar_req2_rst.mem_Rd", mem_Rd, 0);
    chk("ar_req2_rst.mem_Addr", mem_Addr, 16'h0);
    @(negedge clk); rst = 1'b1; drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0);
    $display("txn async reset: checked");

    // Misaligned load -> terminal error, never a strobe
    @(negedge clk); drive(1, 1, 0, 16'h0011, 16'h0, 0, 0, 16'h0); #2;
    chk("mis_idle.stall", Stall_out, 0);
    chk("mis_idle.mem_Rd", mem_Rd, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(1, 1, 0, 16'h0010, 16'h0, 0, 1, 16'h7777); #2;
      chk($sformatf("mis_err%0d.err", k), err, 1);
      chk($sformatf("mis_err%0d.stall", k), Stall_out, 1);
      chk($sformatf("mis_err%0d.mem_Rd", k), mem_Rd, 0);
      chk($sformatf("mis_err%0d.done", k), Done_out, 0);
    end
    $display("txn misaligned: checked");

    // Read and write together -> error
    do_reset();
    @(negedge clk); drive(1, 1, 1, 16'h0040, 16'hAAAA, 0, 0, 16'h0); #2;
    chk("rw_idle.stall", Stall_out, 0);
    @(negedge clk); #2;
    chk("rw_err.err", err, 1);
    chk("rw_err.mem_Wr", mem_Wr, 0);
    $display("txn read+write conflict: checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
